// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding-source
// encoding and the per-stage shadow record.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wren;
    logic       is_load;
  } stage_info_t;

  localparam stage_info_t STAGE_BUBBLE = '0;

  // Younger producer (EX) wins over older (MEM); no match reads the regfile.
  function automatic fwd_sel_e pick_fwd(input logic hit_ex, input logic hit_mem);
    if (hit_ex)       return FWD_MEM;
    else if (hit_mem) return FWD_WB;
    else              return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// One source operand compared against one stage record. x0 never matches
// because it is hardwired to zero and never a real dependency.
module hazard_cmp (
  input  logic       used_i,
  input  logic [4:0] rs_i,
  input  logic       stage_valid_i,
  input  logic [4:0] stage_rd_i,
  input  logic       stage_wren_i,
  output logic       match_o
);

  assign match_o = used_i && stage_valid_i && stage_wren_i &&
                   (stage_rd_i == rs_i) && (stage_rd_i != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks the EX/MEM/WB destination records,
// raises load-use (or, without forwarding, any RAW) stalls, registers the
// EX operand forwarding selects and generates branch flushes.
// Build option: define HAZARD_FORWARD_EN to enable forwarding; when it is
// undefined, forwarding selects stay at the regfile and every in-flight
// RAW dependency stalls until the producer has retired.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] id_rd_addr,
  input  logic       id_rd_wren,
  input  logic       id_is_load,
  input  logic       id_valid,
  input  logic       ex_br_taken,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall_if,
  output logic       stall_id,
  output logic       flush_id,
  output logic       flush_ex
);

  stage_info_t ex_q, mem_q, wb_q;
  stage_info_t ex_d;
  fwd_sel_e    fwd_a_q, fwd_b_q;
  fwd_sel_e    fwd_a_d, fwd_b_d;

  logic [1:0]  src_used;
  logic [4:0]  src_addr [2];
  logic [1:0]  hit_ex;
  logic [1:0]  hit_mem;
  logic        raw_stall;
  logic        stall;
  logic        flush;
  logic        unused_bits;

  assign src_used    = {id_rs2_used, id_rs1_used};
  assign src_addr[0] = id_rs1_addr;
  assign src_addr[1] = id_rs2_addr;

  // One comparator per source per tracked stage.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    hazard_cmp u_cmp_ex (
      .used_i       (src_used[gi]),
      .rs_i         (src_addr[gi]),
      .stage_valid_i(ex_q.valid),
      .stage_rd_i   (ex_q.rd),
      .stage_wren_i (ex_q.wren),
      .match_o      (hit_ex[gi])
    );
    hazard_cmp u_cmp_mem (
      .used_i       (src_used[gi]),
      .rs_i         (src_addr[gi]),
      .stage_valid_i(mem_q.valid),
      .stage_rd_i   (mem_q.rd),
      .stage_wren_i (mem_q.wren),
      .match_o      (hit_mem[gi])
    );
  end

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time; WB matches are resolved
  // by the regfile's write-before-read, so wb_q is tracked but not compared.
  assign raw_stall   = ex_q.is_load && (|hit_ex);
  assign unused_bits = ^wb_q;
`else
  logic [1:0] hit_wb;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src_wb
    hazard_cmp u_cmp_wb (
      .used_i       (src_used[gi]),
      .rs_i         (src_addr[gi]),
      .stage_valid_i(wb_q.valid),
      .stage_rd_i   (wb_q.rd),
      .stage_wren_i (wb_q.wren),
      .match_o      (hit_wb[gi])
    );
  end

  // No bypass network: wait until the producer has left WB.
  assign raw_stall   = (|hit_ex) || (|hit_mem) || (|hit_wb);
  assign unused_bits = wb_q.is_load;
`endif

  // A taken branch squashes the ID instruction, so any stall it caused is moot.
  assign flush = ex_br_taken && !rst;
  assign stall = raw_stall && !ex_br_taken && !rst;

  assign stall_if  = stall;
  assign stall_id  = stall;
  assign flush_id  = flush;
  assign flush_ex  = flush;
  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  // Next EX record and forwarding selects for whatever enters EX next edge.
  always_comb begin
    ex_d    = STAGE_BUBBLE;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;
    if (!stall && !flush) begin
      ex_d.valid   = id_valid;
      ex_d.rd      = id_rd_addr;
      ex_d.wren    = id_rd_wren;
      ex_d.is_load = id_is_load;
`ifdef HAZARD_FORWARD_EN
      if (id_valid) begin
        fwd_a_d = pick_fwd(hit_ex[0], hit_mem[0]);
        fwd_b_d = pick_fwd(hit_ex[1], hit_mem[1]);
      end
`endif
    end
  end

  // Advance the shadow pipeline and latch the forwarding selects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= STAGE_BUBBLE;
      mem_q   <= STAGE_BUBBLE;
      wb_q    <= STAGE_BUBBLE;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Expectations adapt to whether
// HAZARD_FORWARD_EN is defined for the build.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [1:0] S_RF  = 2'b00;
  localparam logic [1:0] S_MEM = 2'b01;
  localparam logic [1:0] S_WB  = 2'b10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
  logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic       id_rd_wren = 1'b0, id_is_load = 1'b0, id_valid = 1'b0;
  logic       ex_br_taken = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_if, stall_id, flush_id, flush_ex;

  typedef struct {
    string      name;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;
  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_wren(id_rd_wren),
    .id_is_load(id_is_load), .id_valid(id_valid),
    .ex_br_taken(ex_br_taken),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge to sample combinational outputs.
  task automatic mid();
    #4;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rd, input logic wr,
                        input logic ld, input logic [4:0] r1, input logic u1,
                        input logic [4:0] r2, input logic u2);
    id_valid = v; id_rd_addr = rd; id_rd_wren = wr; id_is_load = ld;
    id_rs1_addr = r1; id_rs1_used = u1; id_rs2_addr = r2; id_rs2_used = u2;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic drain();
    nop();
    ex_br_taken = 1'b0;
    repeat (4) tick();
  endtask

  task automatic push_exp(input string name, input logic [1:0] a, input logic [1:0] b);
    exp_t e;
    e.name = name; e.a = a; e.b = b;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_br_taken = 1'b1;
    set_id(1'b1, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1);
    tick(); mid();
    n_tests++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_fwd: got %b/%b want 00/00", fwd_a_sel, fwd_b_sel);
    end
    n_tests++;
    if ({stall_if, stall_id, flush_id, flush_ex} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctl: got si=%b sd=%b fi=%b fe=%b want 0000",
                         stall_if, stall_id, flush_id, flush_ex);
    end
    $display("[TB] reset: fwd=%b/%b stall=%b flush=%b", fwd_a_sel, fwd_b_sel, stall_if, flush_id);
    tick();
    ex_br_taken = 1'b0;
    nop();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fwd_ex();
    exp_t e;
    set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);  // add x5
    tick();
    set_id(1'b1, 5'd4, 1'b1, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1);  // sub rs1=x5
    mid();
    n_tests++;
    if (stall_if !== !FWD) begin
      n_fail++; $display("FAIL fwd_ex_stall: got %b want %b", stall_if, !FWD);
    end
    push_exp("fwd_ex", FWD ? S_MEM : S_RF, S_RF);
    tick();
    e = sb_q.pop_front();
    n_tests++;
    if (fwd_a_sel !== e.a || fwd_b_sel !== e.b) begin
      n_fail++; $display("FAIL %s: got %b/%b want %b/%b", e.name, fwd_a_sel, fwd_b_sel, e.a, e.b);
    end
    $display("[TB] fwd_ex: stall=%b fwd=%b/%b", stall_if, fwd_a_sel, fwd_b_sel);
    drain();
  endtask

  task automatic test_load_use();
    exp_t e;
    set_id(1'b1, 5'd6, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);  // lw x6
    tick();
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd6, 1'b1);  // add rs2=x6
    mid();
    n_tests++;
    if (stall_if !== 1'b1 || stall_id !== 1'b1) begin
      n_fail++; $display("FAIL load_use_stall: got %b/%b want 1/1", stall_if, stall_id);
    end
    push_exp("load_use_bubble", S_RF, S_RF);
    tick();
    e = sb_q.pop_front();
    n_tests++;
    if (fwd_a_sel !== e.a || fwd_b_sel !== e.b) begin
      n_fail++; $display("FAIL %s: got %b/%b want %b/%b", e.name, fwd_a_sel, fwd_b_sel, e.a, e.b);
    end
    mid();
    n_tests++;
    if (stall_if !== !FWD) begin
      n_fail++; $display("FAIL load_use_release: got %b want %b", stall_if, !FWD);
    end
    if (!FWD) begin
      tick(); mid();
      n_tests++;
      if (stall_if !== 1'b1) begin
        n_fail++; $display("FAIL load_use_wb_stall: got %b want 1", stall_if);
      end
      tick(); mid();
    end
    push_exp("load_use_fwd", S_RF, FWD ? S_WB : S_RF);
    tick();
    e = sb_q.pop_front();
    n_tests++;
    if (fwd_a_sel !== e.a || fwd_b_sel !== e.b) begin
      n_fail++; $display("FAIL %s: got %b/%b want %b/%b", e.name, fwd_a_sel, fwd_b_sel, e.a, e.b);
    end
    $display("[TB] load_use: fwd=%b/%b", fwd_a_sel, fwd_b_sel);
    drain();
  endtask

  task automatic test_x0();
    exp_t e;
    set_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0);  // addi x0
    tick();
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);  // reads x0
    mid();
    n_tests++;
    if (stall_if !== 1'b0) begin
      n_fail++; $display("FAIL x0_stall: got %b want 0", stall_if);
    end
    push_exp("x0_fwd", S_RF, S_RF);
    tick();
    e = sb_q.pop_front();
    n_tests++;
    if (fwd_a_sel !== e.a || fwd_b_sel !== e.b) begin
      n_fail++; $display("FAIL %s: got %b/%b want %b/%b", e.name, fwd_a_sel, fwd_b_sel, e.a, e.b);
    end
    $display("[TB] x0: stall=%b fwd=%b/%b", stall_if, fwd_a_sel, fwd_b_sel);
    drain();
  endtask

  task automatic test_flush();
    exp_t e;
    set_id(1'b1, 5'd6, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);  // lw x6
    tick();
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd6, 1'b1);  // add rs2=x6
    ex_br_taken = 1'b1;
    mid();
    n_tests++;
    if ({flush_id, flush_ex, stall_if, stall_id} !== 4'b1100) begin
      n_fail++; $display("FAIL flush_over_stall: got fi=%b fe=%b si=%b sd=%b want 1100",
                         flush_id, flush_ex, stall_if, stall_id);
    end
    push_exp("flush_bubble", S_RF, S_RF);
    tick();
    ex_br_taken = 1'b0;
    nop();
    e = sb_q.pop_front();
    n_tests++;
    if (fwd_a_sel !== e.a || fwd_b_sel !== e.b) begin
      n_fail++; $display("FAIL %s: got %b/%b want %b/%b", e.name, fwd_a_sel, fwd_b_sel, e.a, e.b);
    end
    n_tests++;
    if (dut.ex_q.valid !== 1'b0) begin
      n_fail++; $display("FAIL flush_ex_valid: got %b want 0", dut.ex_q.valid);
    end
    mid();
    n_tests++;
    if (flush_id !== 1'b0 || flush_ex !== 1'b0) begin
      n_fail++; $display("FAIL flush_one_cycle: got %b/%b want 0/0", flush_id, flush_ex);
    end
    $display("[TB] flush: ex_valid=%b flush=%b", dut.ex_q.valid, flush_id);
    drain();
  endtask

  task automatic test_rst_stall();
    exp_t e;
    set_id(1'b1, 5'd6, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);  // lw x6
    tick();
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd6, 1'b1);  // add rs2=x6
    mid();
    n_tests++;
    if (stall_if !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre_stall: got %b want 1", stall_if);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({stall_if, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel} !== 8'h00) begin
      n_fail++; $display("FAIL rst_mid_stall: got si=%b sd=%b fwd=%b/%b want 0/0/00/00",
                         stall_if, stall_id, fwd_a_sel, fwd_b_sel);
    end
    tick();
    rst = 1'b0;
    mid();
    n_tests++;
    if (stall_if !== 1'b0) begin
      n_fail++; $display("FAIL rst_release_stall: got %b want 0", stall_if);
    end
    push_exp("rst_enter_ex", S_RF, S_RF);
    tick();
    e = sb_q.pop_front();
    n_tests++;
    if (fwd_a_sel !== e.a || fwd_b_sel !== e.b || dut.ex_q.valid !== 1'b1) begin
      n_fail++; $display("FAIL %s: got %b/%b v=%b want %b/%b v=1",
                         e.name, fwd_a_sel, fwd_b_sel, dut.ex_q.valid, e.a, e.b);
    end
    $display("[TB] rst_stall: ex_valid=%b fwd=%b/%b", dut.ex_q.valid, fwd_a_sel, fwd_b_sel);
    drain();
  endtask

  task automatic test_noforward_stall();
    exp_t e;
    int   stalls = 0;
    set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);  // add x7
    tick();
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);  // or rs1=x7
    for (int i = 0; i < 6; i++) begin
      mid();
      if (stall_if !== 1'b1) break;
      stalls++;
      tick();
      n_tests++;
      if (fwd_a_sel !== S_RF) begin
        n_fail++; $display("FAIL nofwd_hold_sel: got %b want 00", fwd_a_sel);
      end
    end
    n_tests++;
    if (stalls !== (FWD ? 0 : 3)) begin
      n_fail++; $display("FAIL nofwd_stall_count: got %0d want %0d", stalls, FWD ? 0 : 3);
    end
    push_exp("nofwd_enter", FWD ? S_MEM : S_RF, S_RF);
    tick();
    e = sb_q.pop_front();
    n_tests++;
    if (fwd_a_sel !== e.a || fwd_b_sel !== e.b) begin
      n_fail++; $display("FAIL %s: got %b/%b want %b/%b", e.name, fwd_a_sel, fwd_b_sel, e.a, e.b);
    end
    $display("[TB] nofwd: stalls=%0d fwd=%b/%b", stalls, fwd_a_sel, fwd_b_sel);
    drain();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    // x8 in MEM feeds rs1, x9 in EX feeds rs2.
    set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0); tick();
    set_id(1'b1, 5'd9, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0); tick();
    set_id(1'b1, 5'd12, 1'b1, 1'b0, 5'd8, 1'b1, 5'd9, 1'b1);
    mid();
    n_tests++;
    if (stall_if !== !FWD) begin
      n_fail++; $display("FAIL b2b_stall: got %b want %b", stall_if, !FWD);
    end
    push_exp("b2b_fwd", FWD ? S_WB : S_RF, FWD ? S_MEM : S_RF);
    tick();
    e = sb_q.pop_front();
    n_tests++;
    if (fwd_a_sel !== e.a || fwd_b_sel !== e.b) begin
      n_fail++; $display("FAIL %s: got %b/%b want %b/%b", e.name, fwd_a_sel, fwd_b_sel, e.a, e.b);
    end
    $display("[TB] b2b: fwd=%b/%b", fwd_a_sel, fwd_b_sel);
    drain();
    // x10 written twice: the younger write (EX) wins.
    set_id(1'b1, 5'd10, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0); tick();
    set_id(1'b1, 5'd10, 1'b1, 1'b0, 5'd2, 1'b1, 5'd0, 1'b0); tick();
    set_id(1'b1, 5'd12, 1'b1, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0);
    mid();
    push_exp("b2b_priority", FWD ? S_MEM : S_RF, S_RF);
    tick();
    e = sb_q.pop_front();
    n_tests++;
    if (fwd_a_sel !== e.a || fwd_b_sel !== e.b) begin
      n_fail++; $display("FAIL %s: got %b/%b want %b/%b", e.name, fwd_a_sel, fwd_b_sel, e.a, e.b);
    end
    $display("[TB] priority: fwd=%b/%b", fwd_a_sel, fwd_b_sel);
    drain();
    // x11 only in WB: forwarding build ignores it, the other stalls.
    set_id(1'b1, 5'd11, 1'b1, 1'b0, 5'd1, 1'b1, 5'd0, 1'b0); tick();
    nop(); tick(); tick();
    set_id(1'b1, 5'd12, 1'b1, 1'b0, 5'd11, 1'b1, 5'd0, 1'b0);
    mid();
    n_tests++;
    if (stall_if !== !FWD) begin
      n_fail++; $display("FAIL wb_match_stall: got %b want %b", stall_if, !FWD);
    end
    push_exp("wb_match_fwd", S_RF, S_RF);
    tick();
    e = sb_q.pop_front();
    n_tests++;
    if (fwd_a_sel !== e.a || fwd_b_sel !== e.b) begin
      n_fail++; $display("FAIL %s: got %b/%b want %b/%b", e.name, fwd_a_sel, fwd_b_sel, e.a, e.b);
    end
    $display("[TB] wb_match: stall=%b fwd=%b/%b", stall_if, fwd_a_sel, fwd_b_sel);
    drain();
  endtask

  initial begin
    #1;
    test_reset();
    test_fwd_ex();
    test_load_use();
    test_x0();
    test_flush();
    test_rst_stall();
    test_noforward_stall();
    test_back_to_back();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 SHALL have port clk, in, 1: pipeline clock, rising edge.
REQ-003 SHALL have port rst, in, 1: asynchronous active-high reset.
REQ-004 SHALL have ports id_rs1_addr, id_rs2_addr, in, 5 each: source registers of the ID-stage instruction.
REQ-005 SHALL have ports id_rs1_used, id_rs2_used, in, 1 each: the ID instruction reads that source.
REQ-006 SHALL have ports id_rd_addr, in, 5; id_rd_wren, in, 1; id_is_load, in, 1; id_valid, in, 1: ID instruction destination and class.
REQ-007 SHALL have port ex_br_taken, in, 1: a branch or jump resolved taken in EX this cycle.
REQ-008 SHALL have ports fwd_a_sel, fwd_b_sel, out, 2 each: EX operand source for rs1 and rs2 (00 regfile, 01 MEM result, 10 WB data).
REQ-009 SHALL have ports stall_if, stall_id, out, 1 each: hold the PC and the IF/ID register.
REQ-010 SHALL have ports flush_id, flush_ex, out, 1 each: clear the IF/ID and ID/EX registers to a bubble.

Function
REQ-011 SHALL keep shadow stage records ex_q, mem_q and wb_q, each holding {valid, rd, wren, is_load}.
REQ-012 SHALL advance stage records every cycle: wb_q<=mem_q and mem_q<=ex_q.
REQ-013 SHALL load ex_q from the ID inputs, or a bubble (valid=0) when stall_id or flush_ex is asserted.
REQ-014 SHALL treat a source as matching a stage only when used=1, stage valid=1, wren=1, rd equals rs, and rd!=0.
REQ-015 SHALL assert stall_if and stall_id combinationally, same cycle, when a source matches ex_q and ex_q.is_load=1 (load-use, exactly one bubble).
REQ-016 SHALL register fwd_x_sel at the edge where the ID instruction moves into EX: 01 if it matched ex_q, else 10 if it matched mem_q, else 00.
REQ-017 SHALL give the younger producer priority: with an ex_q and mem_q match both present, fwd_x_sel=01.
REQ-018 SHALL assert flush_id and flush_ex for exactly the cycle in which ex_br_taken=1.
REQ-019 SHALL let a flush override a stall: when ex_br_taken=1, stall_if=stall_id=0 and the pending load-use stall is discarded.
REQ-020 SHALL set fwd_x_sel=00 on a bubble entering EX.
REQ-021 SHALL never flag a hazard on a WB-stage match, because regfile write-then-read within the cycle is the regfile's responsibility.

Reset
REQ-022 SHALL clear all stage valids and drive fwd_a_sel=fwd_b_sel=00 while rst=1; stall_if, stall_id, flush_id and flush_ex read 0 while rst=1.
REQ-023 SHALL abandon any in-progress stall on reset asserted mid-stall; the first cycle after reset release shows no stall.

Configuration
REQ-024 SHALL use the macro HAZARD_FORWARD_EN.
REQ-025 With HAZARD_FORWARD_EN defined, SHALL behave as REQ-015..REQ-017.
REQ-026 Without HAZARD_FORWARD_EN, SHALL tie fwd_x_sel to 00 and stall while any source matches ex_q, mem_q or wb_q, regardless of is_load.
REQ-027 In both configurations, SHALL leave flush behaviour unchanged.

Structure
REQ-028 SHALL place the fwd_sel_e enum (FWD_RF=00, FWD_MEM=01, FWD_WB=10) and the stage_info_t struct in shared package hazard_pkg.
REQ-029 SHALL implement one sub-module, hazard_cmp (a source vs. stage-record match), instantiated per source per stage.

Verification
REQ-030 SHALL cover this scenario: add x5 in ID, next cycle sub rs1=x5 in ID -> no stall; sub in EX sees fwd_a_sel=01.
REQ-031 SHALL cover this scenario: lw x6 in EX, add rs2=x6 in ID -> stall_if=stall_id=1 for 1 cycle; then the add in EX has fwd_b_sel=10.
REQ-032 SHALL cover this scenario: addi x0 producer followed by a consumer reading x0 -> no stall, fwd_a_sel=00.
REQ-033 SHALL cover this scenario: ex_br_taken=1 in the same cycle as a load-use stall -> flush_id=flush_ex=1, stall_if=0; next cycle ex_q.valid=0.
REQ-034 SHALL cover this scenario: rst pulsed during a stall -> outputs 0 immediately; next ID instruction enters EX with no stall.
REQ-035 SHALL cover this scenario: without HAZARD_FORWARD_EN, add x7 followed by or rs1=x7 -> stall 3 cycles; fwd_a_sel stays 00.
